// File: rtl/battle_datapath.sv
// Battle datapath: latches stats, computes damage with a shift-add multiplier, applies it to HP with a zero floor.
// Damage is ready STAT_W+1 cycles after a calc_damage rising edge; applies that arrive while busy are deferred to the final edge.
module battle_datapath #(
    parameter int STAT_W = 8,
    parameter int HP_W   = 8,
    parameter int POWER  = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_pm,
    input  logic [STAT_W-1:0] p_atk_in,
    input  logic [STAT_W-1:0] p_def_in,
    input  logic [HP_W-1:0]   p_hp_in,
    input  logic [STAT_W-1:0] ai_atk_in,
    input  logic [STAT_W-1:0] ai_def_in,
    input  logic [HP_W-1:0]   ai_hp_in,
    input  logic              calc_damage,
    input  logic              active_trainer,
    input  logic              apply_damage,
    input  logic              target,
    output logic [HP_W-1:0]   p_hp,
    output logic [HP_W-1:0]   ai_hp,
    output logic              p_hp_zero,
    output logic              ai_hp_zero,
    output logic [HP_W-1:0]   damage,
    output logic              dmg_valid,
    output logic              busy
);

    localparam int ACC_W = STAT_W + 4;
    localparam int RAW_W = ACC_W - 3;
    localparam int CNT_W = $clog2(STAT_W + 1);
    localparam int SAT_W = (RAW_W > HP_W) ? RAW_W : HP_W;
    localparam logic [HP_W-1:0]  HP_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAT_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_SUB} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_calc_d;
    logic               r_apply_d;
    logic [STAT_W-1:0]  r_p_atk;
    logic [STAT_W-1:0]  r_p_def;
    logic [STAT_W-1:0]  r_ai_atk;
    logic [STAT_W-1:0]  r_ai_def;
    logic [HP_W-1:0]    r_p_hp;
    logic [HP_W-1:0]    r_ai_hp;
    logic [HP_W-1:0]    r_damage;
    logic               r_dmg_valid;
    logic               r_pending;
    logic               r_pend_tgt;
    logic [STAT_W-1:0]  r_mplier;
    logic [ACC_W-1:0]   r_mcand;
    logic [ACC_W-1:0]   r_acc;
    logic [STAT_W-1:0]  r_def;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_start;
    logic               w_apl;
    logic               w_busy;
    logic [RAW_W-1:0]   w_raw;
    logic [RAW_W-1:0]   w_def_ext;
    logic [RAW_W-1:0]   w_diff;
    logic [SAT_W-1:0]   w_diff_ext;
    logic [HP_W-1:0]    w_dmg_new;
    logic               w_sub_tgt;

    function automatic logic [HP_W-1:0] f_sub_floor(input logic [HP_W-1:0] hp,
                                                    input logic [HP_W-1:0] dmg);
        return (hp > dmg) ? hp - dmg : '0;
    endfunction

    // FSM controls are level-held, so only rising edges act
    assign w_start = calc_damage  & ~r_calc_d;
    assign w_apl   = apply_damage & ~r_apply_d;

    assign w_raw      = r_acc[ACC_W-1:3];
    assign w_def_ext  = RAW_W'(r_def);
    assign w_diff     = (w_raw > w_def_ext) ? w_raw - w_def_ext : RAW_W'(1);
    assign w_diff_ext = SAT_W'(w_diff);
    assign w_dmg_new  = (w_diff_ext > SAT_W'(HP_MAX)) ? HP_MAX : w_diff_ext[HP_W-1:0];
    assign w_sub_tgt  = w_apl ? target : r_pend_tgt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_calc_d  <= 1'b0;
            r_apply_d <= 1'b0;
        end else begin
            r_calc_d  <= calc_damage;
            r_apply_d <= apply_damage;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (load_pm) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start) w_next = S_MUL;
                S_MUL:   if (r_cnt == CNT_LAST) w_next = S_SUB;
                S_SUB:   w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p_atk     <= '0;
            r_p_def     <= '0;
            r_ai_atk    <= '0;
            r_ai_def    <= '0;
            r_p_hp      <= '0;
            r_ai_hp     <= '0;
            r_damage    <= '0;
            r_dmg_valid <= 1'b0;
            r_pending   <= 1'b0;
            r_pend_tgt  <= 1'b0;
            r_mplier    <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_def       <= '0;
            r_cnt       <= '0;
        end else if (load_pm) begin
            r_p_atk     <= p_atk_in;
            r_p_def     <= p_def_in;
            r_ai_atk    <= ai_atk_in;
            r_ai_def    <= ai_def_in;
            r_p_hp      <= p_hp_in;
            r_ai_hp     <= ai_hp_in;
            r_damage    <= '0;
            r_dmg_valid <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // An apply on the same edge as a start uses the previous damage
                    if (w_apl) begin
                        if (target) r_ai_hp <= f_sub_floor(r_ai_hp, r_damage);
                        else        r_p_hp  <= f_sub_floor(r_p_hp, r_damage);
                    end
                    if (w_start) begin
                        r_mplier    <= active_trainer ? r_ai_atk : r_p_atk;
                        r_def       <= active_trainer ? r_p_def  : r_ai_def;
                        r_mcand     <= ACC_W'(POWER);
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_dmg_valid <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_apl) begin
                        r_pending  <= 1'b1;
                        r_pend_tgt <= target;
                    end
                end
                S_SUB: begin
                    r_damage    <= w_dmg_new;
                    r_dmg_valid <= 1'b1;
                    r_pending   <= 1'b0;
                    if (r_pending || w_apl) begin
                        if (w_sub_tgt) r_ai_hp <= f_sub_floor(r_ai_hp, w_dmg_new);
                        else           r_p_hp  <= f_sub_floor(r_p_hp, w_dmg_new);
                    end
                end
                default: ;
            endcase
        end
    end

    assign p_hp       = r_p_hp;
    assign ai_hp      = r_ai_hp;
    assign p_hp_zero  = (r_p_hp == '0);
    assign ai_hp_zero = (r_ai_hp == '0);
    assign damage     = r_damage;
    assign dmg_valid  = r_dmg_valid;
    assign busy       = w_busy;

endmodule
